// File: rtl/aib_tx_packer_pkg.sv
// Shared types for the AIB Tx packer: flit header layout, framing states, flit widths.
package aib_tx_pkg;

  localparam int FLIT_W = 72;
  localparam int HDR_W  = 8;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [2:0] seq;
    logic       forced_eop;
    logic       restart;
    logic       par;
  } hdr_t;

  typedef enum logic {IDLE = 1'b0, PKT = 1'b1} pk_state_e;

endpackage

// File: rtl/aib_tx_packer_if.sv
// Framed valid/ready stream: used for 64b packet beats in and 72b AIB flits out.
interface aib_tx_packer_if #(
  parameter int W = 64
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;
  logic         sop;
  logic         eop;

  modport master (output valid, data, sop, eop, input ready);
  modport slave  (input valid, data, sop, eop, output ready);
endinterface

// File: rtl/aib_tx_packer_skid_buf.sv
// Two-entry valid/ready skid buffer; head entry drives the outputs straight from a register.
// An empty buffer passes a word through in one cycle; input ready drops only when both entries hold data.
module aib_skid_buf #(
  parameter int W = 72
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_vld,
  output logic         o_rdy,
  input  logic [W-1:0] i_dat,
  output logic         o_vld,
  input  logic         i_rdy,
  output logic [W-1:0] o_dat
);

  logic         r_v0;
  logic         r_v1;
  logic [W-1:0] r_d0;
  logic [W-1:0] r_d1;
  logic         w_push;
  logic         w_pop;

  assign o_rdy  = ~(r_v0 & r_v1);
  assign o_vld  = r_v0;
  assign o_dat  = r_d0;
  assign w_push = i_vld & o_rdy;
  assign w_pop  = r_v0 & i_rdy;

  // r_v1 implies r_v0; a push can never coincide with a full buffer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_d0 <= '0;
      r_d1 <= '0;
    end else if (w_pop) begin
      if (r_v1) begin
        r_d0 <= r_d1;
        r_v1 <= 1'b0;
      end else begin
        r_v0 <= w_push;
        if (w_push) r_d0 <= i_dat;
      end
    end else if (w_push) begin
      if (r_v0) begin
        r_d1 <= i_dat;
        r_v1 <= 1'b1;
      end else begin
        r_d0 <= i_dat;
        r_v0 <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/aib_tx_packer.sv
// Packs sop/eop-framed 64b beats into 72b AIB flits (8b header + payload), enforcing framing and max length.
// Framing errors drop or mark beats; a 2-entry skid stage keeps full rate under i_tx_ready backpressure.
module aib_tx_packer
  import aib_tx_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int HDR_W  = 8,
  parameter int SEQ_W  = 3,
  parameter int CNT_W  = 8
) (
  input  logic              i_aib_clk,
  input  logic              i_rst,
  input  logic              c_en,
  input  logic [CNT_W-1:0]  c_max_len,
  aib_tx_packer_if.slave    i_beat,
  aib_tx_packer_if.master   o_flit,
  output logic              o_busy,
  output logic              o_err_pulse,
  output logic [CNT_W-1:0]  o_err_cnt
);

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_PKT  = PKT;

  logic [0:0]              r_state;
  logic [CNT_W-1:0]        r_len;
  logic [SEQ_W-1:0]        r_seq;
  logic                    r_err_pulse;
  logic [CNT_W-1:0]        r_err_cnt;

  logic                    w_skid_rdy;
  logic                    w_accept;
  logic                    w_emit;
  logic                    w_drop;
  logic                    w_restart;
  logic                    w_forced;
  logic                    w_err;
  logic [0:0]              w_nxt_state;
  logic [CNT_W-1:0]        w_nxt_len;
  hdr_t                    w_hdr;
  logic [HDR_W+DATA_W-1:0] w_flit;
  logic                    w_tx_vld;
  logic [FLIT_W-1:0]       w_tx_dat;

  assign i_beat.ready = c_en & w_skid_rdy;
  assign w_accept     = i_beat.valid & i_beat.ready;

  // Framing decision for the beat currently offered; only committed on accept.
  always_comb begin
    w_drop      = 1'b0;
    w_restart   = 1'b0;
    w_forced    = 1'b0;
    w_nxt_state = r_state;
    w_nxt_len   = r_len;
    if (r_state == ST_IDLE && !i_beat.sop) begin
      w_drop = 1'b1;
    end else begin
      w_restart = (r_state == ST_PKT) && i_beat.sop;
      if (i_beat.sop)
        w_nxt_len = CNT_W'(1);
      else if (r_len != '1)
        w_nxt_len = r_len + CNT_W'(1);
      if (i_beat.eop) begin
        w_nxt_state = ST_IDLE;
      end else if (c_max_len != '0 && w_nxt_len == c_max_len) begin
        w_forced    = 1'b1;
        w_nxt_state = ST_IDLE;
      end else begin
        w_nxt_state = ST_PKT;
      end
    end
  end

  assign w_err  = w_drop | w_restart | w_forced;
  assign w_emit = w_accept & ~w_drop;

  always_comb begin
    w_hdr.sop        = i_beat.sop;
    w_hdr.eop        = i_beat.eop | w_forced;
    w_hdr.seq        = r_seq;
    w_hdr.forced_eop = w_forced;
    w_hdr.restart    = w_restart;
    w_hdr.par        = ^i_beat.data;
  end

  assign w_flit = {w_hdr, i_beat.data};

  always_ff @(posedge i_aib_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_seq       <= '0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_err_pulse <= w_accept & w_err;
      if (w_accept) begin
        r_state <= w_nxt_state;
        r_len   <= w_nxt_len;
        if (w_err && r_err_cnt != '1)
          r_err_cnt <= r_err_cnt + CNT_W'(1);
      end
      if (w_emit)
        r_seq <= r_seq + SEQ_W'(1);
    end
  end

  aib_skid_buf #(
    .W (FLIT_W)
  ) u_skid (
    .i_clk (i_aib_clk),
    .i_rst (i_rst),
    .i_vld (w_emit),
    .o_rdy (w_skid_rdy),
    .i_dat (w_flit),
    .o_vld (w_tx_vld),
    .i_rdy (o_flit.ready),
    .o_dat (w_tx_dat)
  );

  assign o_flit.valid = w_tx_vld;
  assign o_flit.data  = w_tx_dat;
  assign o_flit.sop   = w_tx_dat[FLIT_W-1];
  assign o_flit.eop   = w_tx_dat[FLIT_W-2];

  assign o_busy      = (r_state == ST_PKT);
  assign o_err_pulse = r_err_pulse;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_aib_tx_packer.sv
// Directed bench for aib_tx_packer: vector table for framing/length rules, hand sequences for backpressure and reset.
module tb_aib_tx_packer;
  import aib_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       c_en;
  logic [7:0] c_max_len;
  logic       o_busy;
  logic       o_err_pulse;
  logic [7:0] o_err_cnt;

  aib_tx_packer_if #(.W(64)) beat_if ();
  aib_tx_packer_if #(.W(72)) flit_if ();

  always #5 clk = ~clk;

  aib_tx_packer dut (
    .i_aib_clk   (clk),
    .i_rst       (rst),
    .c_en        (c_en),
    .c_max_len   (c_max_len),
    .i_beat      (beat_if),
    .o_flit      (flit_if),
    .o_busy      (o_busy),
    .o_err_pulse (o_err_pulse),
    .o_err_cnt   (o_err_cnt)
  );

  typedef struct {
    logic       vld, sop, eop;
    logic [7:0] max_len;
    logic       x_vld, x_sop, x_eop;
    logic [2:0] x_seq;
    logic       x_f, x_r, x_errp;
    logic [7:0] x_cnt;
    logic       x_busy;
  } vec_t;

  vec_t vq[$];
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic add(input logic vld, sop, eop, input logic [7:0] ml,
                     input logic xv, xs, xe, input logic [2:0] xq, input logic xf, xr, xp,
                     input logic [7:0] xc, input logic xb);
    vec_t v;
    v.vld = vld; v.sop = sop; v.eop = eop; v.max_len = ml;
    v.x_vld = xv; v.x_sop = xs; v.x_eop = xe; v.x_seq = xq; v.x_f = xf; v.x_r = xr;
    v.x_errp = xp; v.x_cnt = xc; v.x_busy = xb;
    vq.push_back(v);
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'(i) * 32'h9E37_79B9};
  endfunction

  function automatic logic [71:0] flit(input logic s, e, input logic [2:0] q,
                                        input logic f, r, input logic [63:0] d);
    return {s, e, q, f, r, ^d, d};
  endfunction

  task automatic drive(input logic v, s, e, input logic [63:0] d);
    beat_if.valid = v;
    beat_if.sop   = s;
    beat_if.eop   = e;
    beat_if.data  = d;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    c_en = 1'b1;
    c_max_len = 8'd0;
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    flit_if.ready = 1'b1;

    // Table: vld sop eop max | x_vld x_sop x_eop x_seq x_f x_r x_errp x_cnt x_busy
    add(1,1,0,0, 1,1,0,3'd0,0,0, 0,8'd0,1);  // 3-beat packet
    add(1,0,0,0, 1,0,0,3'd1,0,0, 0,8'd0,1);
    add(1,0,1,0, 1,0,1,3'd2,0,0, 0,8'd0,0);
    add(1,0,0,0, 0,0,0,3'd0,0,0, 1,8'd1,0);  // no sop in IDLE: dropped
    add(0,0,0,0, 0,0,0,3'd0,0,0, 0,8'd1,0);
    add(1,1,0,0, 1,1,0,3'd3,0,0, 0,8'd1,1);  // sop inside packet
    add(1,1,0,0, 1,1,0,3'd4,0,1, 1,8'd2,1);
    add(1,0,1,0, 1,0,1,3'd5,0,0, 0,8'd2,0);
    add(1,1,0,4, 1,1,0,3'd6,0,0, 0,8'd2,1);  // max_len=4, 6-beat packet
    add(1,0,0,4, 1,0,0,3'd7,0,0, 0,8'd2,1);
    add(1,0,0,4, 1,0,0,3'd0,0,0, 0,8'd2,1);
    add(1,0,0,4, 1,0,1,3'd1,1,0, 1,8'd3,0);
    add(1,0,0,4, 0,0,0,3'd0,0,0, 1,8'd4,0);
    add(1,0,1,4, 0,0,0,3'd0,0,0, 1,8'd5,0);
    add(1,1,0,1, 1,1,1,3'd2,1,0, 1,8'd6,0);  // max_len=1 truncates at sop
    add(1,1,0,0, 1,1,0,3'd3,0,0, 0,8'd6,1);
    add(1,1,0,1, 1,1,1,3'd4,1,1, 1,8'd7,0);  // restart + forced count once
    add(1,1,1,0, 1,1,1,3'd5,0,0, 0,8'd7,0);

    repeat (2) @(negedge clk);
    chk("rst_tx_valid", flit_if.valid, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_err_cnt", o_err_cnt, 8'd0);
    chk("rst_err_pulse", o_err_pulse, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_ready", beat_if.ready, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      logic [63:0] d;
      v = vq[i];
      d = pat(i);
      @(negedge clk);
      c_max_len = v.max_len;
      drive(v.vld, v.sop, v.eop, d);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_tx_valid", i), flit_if.valid, v.x_vld);
      if (v.x_vld)
        chk($sformatf("v%0d_flit", i), flit_if.data, flit(v.x_sop, v.x_eop, v.x_seq, v.x_f, v.x_r, d));
      chk($sformatf("v%0d_err_pulse", i), o_err_pulse, v.x_errp);
      chk($sformatf("v%0d_err_cnt", i), o_err_cnt, v.x_cnt);
      chk($sformatf("v%0d_busy", i), o_busy, v.x_busy);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    c_max_len = 8'd0;

    // Ten single-beat packets against a 1010 ready pattern.
    pulse_reset();
    begin
      int sent, rcv, occ;
      logic held, acc, take;
      logic [71:0] hold_dat;
      sent = 0; rcv = 0; occ = 0; held = 1'b0; hold_dat = '0;
      for (int cyc = 0; cyc < 200 && rcv < 10; cyc++) begin
        @(negedge clk);
        flit_if.ready = (cyc % 2 == 0);
        drive(sent < 10, 1'b1, 1'b1, pat(100 + sent));
        #1;
        chk("t2_ready_vs_full", beat_if.ready, occ < 2);
        if (held) begin
          chk("t2_hold_valid", flit_if.valid, 1'b1);
          chk("t2_hold_data", flit_if.data, hold_dat);
        end
        acc  = beat_if.valid & beat_if.ready;
        take = flit_if.valid & flit_if.ready;
        if (take) begin
          chk("t2_flit", flit_if.data, flit(1'b1, 1'b1, 3'(rcv), 1'b0, 1'b0, pat(100 + rcv)));
          rcv++;
        end
        held     = flit_if.valid & ~flit_if.ready;
        hold_dat = flit_if.data;
        if (acc) sent++;
        occ = occ + int'(acc) - int'(take);
      end
      chk("t2_flit_count", 72'(rcv), 72'd10);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 64'd0);
      #1;
      chk("t2_no_extra", flit_if.valid, 1'b0);
    end

    // c_en stall mid-packet, fill the skid, then reset with flits buffered.
    pulse_reset();
    flit_if.ready = 1'b0;
    drive(1'b1, 1'b1, 1'b0, pat(200));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    c_en = 1'b0;
    #1;
    chk("t6_cen_ready", beat_if.ready, 1'b0);
    chk("t6_cen_busy", o_busy, 1'b1);
    @(negedge clk);
    c_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, pat(201));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 64'd0);
    #1;
    chk("t6_full_ready", beat_if.ready, 1'b0);
    chk("t6_full_busy", o_busy, 1'b1);
    chk("t6_head_flit", flit_if.data, flit(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, pat(200)));
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_tx_valid", flit_if.valid, 1'b0);
    chk("t6_rst_busy", o_busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    flit_if.ready = 1'b1;
    drive(1'b1, 1'b1, 1'b1, pat(210));
    @(posedge clk);
    #1;
    chk("t6_post_valid", flit_if.valid, 1'b1);
    chk("t6_post_seq0", flit_if.data, flit(1'b1, 1'b1, 3'd0, 1'b0, 1'b0, pat(210)));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
